// File: rtl/mpu_pkg.sv
// Shared defaults, phase encoding and instruction-class constants for the
// program controller.
package mpu_pkg;

  localparam int unsigned MPU_ADDR_W      = 10;
  localparam int unsigned MPU_STACK_DEPTH = 16;
  localparam int unsigned MPU_RESET_VEC   = 0;

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

  // Instruction class as {reti, ret, call, jump}
  localparam logic [3:0] CLS_JUMP = 4'b0001;
  localparam logic [3:0] CLS_CALL = 4'b0010;
  localparam logic [3:0] CLS_RET  = 4'b0100;
  localparam logic [3:0] CLS_RETI = 4'b1000;

endpackage

// File: rtl/prog_stack.sv
// Return-stack storage: synchronous write, asynchronous read.
module prog_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/progctl3.sv
// Two-phase program controller: PC sequencing, circular return stack,
// interrupt accept with shadow flags and sticky stack error flags.
module progctl3 import mpu_pkg::*; #(
  parameter int unsigned        ADDR_W      = MPU_ADDR_W,
  parameter int unsigned        STACK_DEPTH = MPU_STACK_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = ADDR_W'(MPU_RESET_VEC),
  parameter logic [ADDR_W-1:0]  INT_VEC     = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         reti,
  input  logic                         cond_ok,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         ie_set,
  input  logic                         ie_clr,
  input  logic                         reti_ie,
  input  logic                         interrupt,
  input  logic                         c_in,
  input  logic                         z_in,
  input  logic                         err_clr,
  output logic                         ph,
  output logic [ADDR_W-1:0]            addr,
  output logic                         int_ack,
  output logic                         flg_restore,
  output logic                         c_out,
  output logic                         z_out,
  output logic [$clog2(STACK_DEPTH):0] sp_level,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  logic              ie;
  logic [PTR_W-1:0]  sp_ptr;
  logic [PTR_W-1:0]  ptr_dec;
  logic [ADDR_W-1:0] pop_data;
  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        cls;
  logic              is_jump, is_call, is_ret, is_reti;
  logic              exec_edge;
  logic              do_push, do_pop;
  logic              stk_full, stk_empty;
  logic              stk_we;

  assign cls       = {reti, ret, call, jump};
  assign is_jump   = |(cls & CLS_JUMP);
  assign is_call   = |(cls & CLS_CALL);
  assign is_ret    = |(cls & CLS_RET);
  assign is_reti   = |(cls & CLS_RETI);
  assign exec_edge = (ph == PH_EXEC);
  assign ptr_dec   = sp_ptr - 1'b1;
  assign stk_full  = (sp_level == LVL_FULL);
  assign stk_empty = (sp_level == '0);

  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    next_addr = addr + 1'b1;
    if (int_ack) begin
      do_push   = exec_edge;
      next_addr = INT_VEC;
    end else if (is_reti) begin
      do_pop    = exec_edge;
      next_addr = pop_data;
    end else if (is_ret && cond_ok) begin
      do_pop    = exec_edge;
      next_addr = pop_data + 1'b1;
    end else if (is_call && cond_ok) begin
      do_push   = exec_edge;
      next_addr = target;
    end else if (is_jump && cond_ok) begin
      next_addr = target;
    end
  end

  // Reset aborts the in-flight push so stack RAM is never written under rst
  assign stk_we = do_push && !rst;

  prog_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .we    (stk_we),
    .waddr (sp_ptr),
    .wdata (addr),
    .raddr (ptr_dec),
    .rdata (pop_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ph          <= PH_FETCH;
      addr        <= RESET_VEC;
      ie          <= 1'b0;
      int_ack     <= 1'b0;
      flg_restore <= 1'b0;
      c_out       <= 1'b0;
      z_out       <= 1'b0;
      sp_level    <= '0;
      sp_ptr      <= '0;
      stk_ovf     <= 1'b0;
      stk_unf     <= 1'b0;
    end else begin
      ph          <= ~ph;
      int_ack     <= (ph == PH_FETCH) && interrupt && ie;
      flg_restore <= 1'b0;
      stk_ovf     <= (stk_ovf && !err_clr) || (do_push && stk_full);
      stk_unf     <= (stk_unf && !err_clr) || (do_pop && stk_empty);
      if (exec_edge) begin
        addr <= next_addr;
        if (int_ack) begin
          ie    <= 1'b0;
          c_out <= c_in;
          z_out <= z_in;
        end else if (is_reti) begin
          ie          <= reti_ie;
          flg_restore <= 1'b1;
        end else if (ie_clr) begin
          ie <= 1'b0;
        end else if (ie_set) begin
          ie <= 1'b1;
        end
        if (do_push) begin
          sp_ptr <= sp_ptr + 1'b1;
          if (!stk_full) sp_level <= sp_level + 1'b1;
        end else if (do_pop) begin
          sp_ptr <= ptr_dec;
          if (!stk_empty) sp_level <= sp_level - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_progctl3.sv
// Scenario bench for progctl3: expected PC/stack level pushed to a queue at
// stimulus time and popped when the instruction completes.
module tb_progctl3;
  import mpu_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned SD = 16;
  localparam int unsigned LW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jump = 0, call = 0, ret = 0, reti = 0, cond_ok = 0;
  logic [AW-1:0] target = '0;
  logic ie_set = 0, ie_clr = 0, reti_ie = 0, interrupt = 0;
  logic c_in = 0, z_in = 0, err_clr = 0;
  logic ph, int_ack, flg_restore, c_out, z_out, stk_ovf, stk_unf;
  logic [AW-1:0] addr;
  logic [LW-1:0] sp_level;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  progctl3 #(
    .ADDR_W      (AW),
    .STACK_DEPTH (SD),
    .RESET_VEC   (10'h000),
    .INT_VEC     (10'h3FF)
  ) dut (
    .clk (clk), .rst (rst),
    .jump (jump), .call (call), .ret (ret), .reti (reti),
    .cond_ok (cond_ok), .target (target),
    .ie_set (ie_set), .ie_clr (ie_clr), .reti_ie (reti_ie),
    .interrupt (interrupt), .c_in (c_in), .z_in (z_in), .err_clr (err_clr),
    .ph (ph), .addr (addr), .int_ack (int_ack), .flg_restore (flg_restore),
    .c_out (c_out), .z_out (z_out), .sp_level (sp_level),
    .stk_ovf (stk_ovf), .stk_unf (stk_unf)
  );

  // One full instruction starting in fetch; returns #1 after the execute edge.
  task automatic run_instr(input logic j, input logic c, input logic r,
                           input logic ri, input logic cond,
                           input logic [AW-1:0] tgt, input logic is,
                           input logic ic, input logic rie);
    jump = j; call = c; ret = r; reti = ri; cond_ok = cond; target = tgt;
    ie_set = is; ie_clr = ic; reti_ie = rie;
    @(posedge clk); #1;
    @(posedge clk); #1;
    jump = 0; call = 0; ret = 0; reti = 0; cond_ok = 0; target = '0;
    ie_set = 0; ie_clr = 0; reti_ie = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ph !== 1'b0 || addr !== 10'h000 || sp_level !== 5'd0 || int_ack !== 1'b0 ||
        flg_restore !== 1'b0 || c_out !== 1'b0 || z_out !== 1'b0 ||
        stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ph=%b addr=%h sp=%0d ack=%b fr=%b c=%b z=%b ovf=%b unf=%b, required all zero",
               ph, addr, sp_level, int_ack, flg_restore, c_out, z_out, stk_ovf, stk_unf);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) exp_q.push_back('{addr: AW'(i), lvl: 5'd0});
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (addr !== e.addr || ph !== PH_FETCH) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: addr=%h ph=%b, required addr=%h ph=0", i, addr, ph, e.addr);
      end
      @(posedge clk); #1;
      checks++;
      if (ph !== PH_EXEC || addr !== e.addr) begin
        errors++;
        $display("FAIL seq_exec[%0d]: addr=%h ph=%b, required addr=%h ph=1", i, addr, ph, e.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call_ret();
    logic [4:0]    dec [5];
    logic [AW-1:0] tgt [5];
    logic          cnd [5];
    dec = '{5'b10001, 5'b10010, 5'b10100, 5'b10010, 5'b10100};
    tgt = '{10'h010, 10'h200, 10'h0AA, 10'h300, 10'h0BB};
    cnd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_q.push_back('{addr: 10'h010, lvl: 5'd0});
    exp_q.push_back('{addr: 10'h200, lvl: 5'd1});
    exp_q.push_back('{addr: 10'h011, lvl: 5'd0});
    exp_q.push_back('{addr: 10'h012, lvl: 5'd0});
    exp_q.push_back('{addr: 10'h013, lvl: 5'd0});
    for (int i = 0; i < 5; i++) begin
      run_instr(dec[i][0], dec[i][1], dec[i][2], 1'b0, cnd[i], tgt[i], 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (addr !== e.addr || sp_level !== e.lvl) begin
        errors++;
        $display("FAIL call_ret[%0d]: addr=%h sp=%0d, required addr=%h sp=%0d", i, addr, sp_level, e.addr, e.lvl);
      end
    end
  endtask

  task automatic test_interrupt();
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (addr !== 10'h006) begin
      errors++; $display("FAIL ie_set_step: addr=%h, required 006", addr);
    end
    // Accepted interrupt; a pending jump in the same slot must be suppressed
    exp_q.push_back('{addr: 10'h3FF, lvl: 5'd1});
    interrupt = 1; c_in = 1; z_in = 0; jump = 1; cond_ok = 1; target = 10'h0AA;
    @(posedge clk); #1;
    interrupt = 0;
    checks++;
    if (int_ack !== 1'b1 || ph !== PH_EXEC) begin
      errors++; $display("FAIL int_ack_exec: int_ack=%b ph=%b, required 1/1", int_ack, ph);
    end
    @(posedge clk); #1;
    jump = 0; cond_ok = 0; target = '0;
    e = exp_q.pop_front();
    checks++;
    if (int_ack !== 1'b0 || addr !== e.addr || sp_level !== e.lvl) begin
      errors++;
      $display("FAIL int_vector: int_ack=%b addr=%h sp=%0d, required 0 %h %0d", int_ack, addr, sp_level, e.addr, e.lvl);
    end
    // IE cleared by the accept: a request now is ignored; 3FF wraps to 000
    interrupt = 1;
    @(posedge clk); #1;
    interrupt = 0;
    checks++;
    if (int_ack !== 1'b0) begin
      errors++; $display("FAIL ie_cleared: int_ack=%b, required 0", int_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (addr !== 10'h000) begin
      errors++; $display("FAIL int_wrap: addr=%h, required 000", addr);
    end
    exp_q.push_back('{addr: 10'h006, lvl: 5'd0});
    c_in = 0; z_in = 1;
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (addr !== e.addr || sp_level !== e.lvl || flg_restore !== 1'b1 || c_out !== 1'b1 || z_out !== 1'b0) begin
      errors++;
      $display("FAIL reti: addr=%h sp=%0d fr=%b c=%b z=%b, required %h %0d 1 1 0",
               addr, sp_level, flg_restore, c_out, z_out, e.addr, e.lvl);
    end
    @(posedge clk); #1;
    checks++;
    if (flg_restore !== 1'b0) begin
      errors++; $display("FAIL flg_pulse: flg_restore=%b, required 0", flg_restore);
    end
    @(posedge clk); #1;
    // IE restored to 1 by reti: accept again, shadow picks up new flags
    exp_q.push_back('{addr: 10'h3FF, lvl: 5'd1});
    interrupt = 1;
    @(posedge clk); #1;
    interrupt = 0;
    checks++;
    if (int_ack !== 1'b1) begin
      errors++; $display("FAIL ie_restored: int_ack=%b, required 1", int_ack);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (addr !== e.addr || sp_level !== e.lvl || c_out !== 1'b0 || z_out !== 1'b1) begin
      errors++;
      $display("FAIL int_second: addr=%h sp=%0d c=%b z=%b, required %h %0d 0 1", addr, sp_level, c_out, z_out, e.addr, e.lvl);
    end
    // reti with reti_ie=0, then ie_set+ie_clr together: clear wins
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0);
    interrupt = 1;
    @(posedge clk); #1;
    interrupt = 0;
    checks++;
    if (int_ack !== 1'b0 || addr !== 10'h008) begin
      errors++; $display("FAIL ie_clr_wins: int_ack=%b addr=%h, required 0 008", int_ack, addr);
    end
    @(posedge clk); #1;
    c_in = 0; z_in = 0;
  endtask

  task automatic test_stack_overflow();
    rst = 1; @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back('{addr: AW'(10'h100 + k), lvl: (k + 1 > 16) ? 5'd16 : LW'(k + 1)});
      run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, AW'(10'h100 + k), 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (addr !== e.addr || sp_level !== e.lvl || stk_ovf !== (k == 16)) begin
        errors++;
        $display("FAIL push[%0d]: addr=%h sp=%0d ovf=%b, required %h %0d %b", k, addr, sp_level, stk_ovf, e.addr, e.lvl, k == 16);
      end
    end
    for (int j = 0; j < 17; j++) begin
      exp_q.push_back('{addr: (j == 16) ? 10'h110 : AW'(10'h110 - j), lvl: (j >= 15) ? 5'd0 : LW'(15 - j)});
      run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (addr !== e.addr || sp_level !== e.lvl || stk_unf !== (j == 16) || stk_ovf !== 1'b1) begin
        errors++;
        $display("FAIL pop[%0d]: addr=%h sp=%0d unf=%b ovf=%b, required %h %0d %b 1",
                 j, addr, sp_level, stk_unf, stk_ovf, e.addr, e.lvl, j == 16);
      end
    end
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    checks++;
    if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      errors++; $display("FAIL err_clr: ovf=%b unf=%b, required 0 0", stk_ovf, stk_unf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_and_abort();
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{addr: 10'h000, lvl: 5'd0});
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h123, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (addr !== e.addr || sp_level !== e.lvl) begin
      errors++; $display("FAIL jump_nc_wrap: addr=%h sp=%0d, required %h %0d", addr, sp_level, e.addr, e.lvl);
    end
    call = 1; cond_ok = 1; target = 10'h2AA;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; call = 0; cond_ok = 0; target = '0;
    checks++;
    if (addr !== 10'h000 || sp_level !== 5'd0 || ph !== PH_FETCH) begin
      errors++; $display("FAIL rst_abort: addr=%h sp=%0d ph=%b, required 000 0 0", addr, sp_level, ph);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_interrupt();
    test_stack_overflow();
    test_wrap_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
